spi_jstk_poller: RTL

- Frame sequencer directly upstream of the byte-level SPI master.
- Periodically runs one 5-byte read frame against the joystick module: owns the slave select, feeds transmit bytes, pulses the master's start, collects each received byte.
- Assembles X/Y position and button state and presents them to the snake game logic with a one-cycle valid strobe.

---
 rtl/spi_jstk_poller_if.sv | 28 ++
 rtl/spi_jstk_poller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_jstk_poller_if.sv
// Byte-level SPI master link used by the joystick frame poller.
// master modport: the poller (drives start/tx/ss_n, reads busy/rx).
// slave modport: the SPI master engine side (drives busy/rx).
`timescale 1ns/1ps

interface spi_jstk_poller_if;
    logic       spi_start;  // one-cycle start pulse
    logic       spi_busy;   // byte transfer in progress
    logic [7:0] spi_tx;     // byte to transmit
    logic [7:0] spi_rx;     // byte received
    logic       ss_n;       // joystick slave select, active-low

    modport master (
        output spi_start,
        output spi_tx,
        output ss_n,
        input  spi_busy,
        input  spi_rx
    );

    modport slave (
        input  spi_start,
        input  spi_tx,
        input  ss_n,
        output spi_busy,
        output spi_rx
    );
endinterface

// File: rtl/spi_jstk_poller.sv
// Joystick poller: periodically runs a 5-byte SPI read frame, assembles X/Y/buttons.
// Latency: sample_valid one cycle after ss_n hold time expires at frame end.
// Backpressure: none downstream; waits on spi_busy handshake from the SPI master.
//
// Ports: clk, rst (sync, active-high); poll_en enables periodic frames; led is
// sent in byte 0; spi (interface, master modport) carries start/tx/rx/busy/ss_n;
// frame_busy, x_pos, y_pos, buttons, sample_valid present the latest sample.
// Optional macro JSTK_DIR_EN adds dir/dir_valid direction decode outputs.
`timescale 1ns/1ps

module spi_jstk_poller #(
    parameter int POLL_DIV     = 2500000,
    parameter int SS_SETUP_CYC = 750,
    parameter int BYTE_GAP_CYC = 500,
`ifdef JSTK_DIR_EN
    parameter int DIR_DEADBAND = 128,
`endif
    parameter int SS_HOLD_CYC  = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               poll_en,
    input  logic [1:0]         led,
    spi_jstk_poller_if.master  spi,
    output logic               frame_busy,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic [2:0]         buttons,
`ifdef JSTK_DIR_EN
    output logic [1:0]         dir,
    output logic               dir_valid,
`endif
    output logic               sample_valid
);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, WAIT_HI, WAIT_LO, GAP, HOLD, DONE
    } state_t;

    // Delay counters count down to 0 from N-1, so N cycles per phase; 0 acts as 1.
    localparam logic [23:0] POLL_LAST = 24'(POLL_DIV - 1);
    localparam logic [23:0] SETUP_LD  = (SS_SETUP_CYC == 0) ? 24'd0 : 24'(SS_SETUP_CYC - 1);
    localparam logic [23:0] GAP_LD    = (BYTE_GAP_CYC == 0) ? 24'd0 : 24'(BYTE_GAP_CYC - 1);
    localparam logic [23:0] HOLD_LD   = (SS_HOLD_CYC  == 0) ? 24'd0 : 24'(SS_HOLD_CYC  - 1);

    state_t      state;
    logic [23:0] poll_cnt;
    logic [23:0] dly_cnt;
    logic [2:0]  idx;

    // Receive buffer; only the bits that reach the outputs are kept.
    logic [7:0]  x_lo;
    logic [1:0]  x_hi;
    logic [7:0]  y_lo;
    logic [1:0]  y_hi;
    logic [2:0]  btn;

    logic [9:0]  x_new;
    logic [9:0]  y_new;
    assign x_new = {x_hi, x_lo};
    assign y_new = {y_hi, y_lo};

`ifdef JSTK_DIR_EN
    // Two's-complement 11-bit offsets from centre; bit 10 is the sign.
    logic [10:0] dx, dy, ax, ay, mag;
    logic        y_win;
    assign dx    = {1'b0, x_new} - 11'd512;
    assign dy    = {1'b0, y_new} - 11'd512;
    assign ax    = dx[10] ? (~dx + 11'd1) : dx;
    assign ay    = dy[10] ? (~dy + 11'd1) : dy;
    assign y_win = (ay >= ax);  // ties resolve to the Y axis
    assign mag   = y_win ? ay : ax;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            poll_cnt      <= '0;
            dly_cnt       <= '0;
            idx           <= '0;
            x_lo          <= '0;
            x_hi          <= '0;
            y_lo          <= '0;
            y_hi          <= '0;
            btn           <= '0;
            spi.spi_start <= 1'b0;
            spi.spi_tx    <= '0;
            spi.ss_n      <= 1'b1;
            frame_busy    <= 1'b0;
            x_pos         <= '0;
            y_pos         <= '0;
            buttons       <= '0;
            sample_valid  <= 1'b0;
`ifdef JSTK_DIR_EN
            dir           <= '0;
            dir_valid     <= 1'b0;
`endif
        end else begin
            spi.spi_start <= 1'b0;
            sample_valid  <= 1'b0;
`ifdef JSTK_DIR_EN
            dir_valid     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!poll_en) begin
                        poll_cnt <= '0;
                    end else if (poll_cnt == POLL_LAST) begin
                        poll_cnt   <= '0;
                        dly_cnt    <= SETUP_LD;
                        spi.ss_n   <= 1'b0;
                        frame_busy <= 1'b1;
                        state      <= SETUP;
                    end else begin
                        poll_cnt <= poll_cnt + 24'd1;
                    end
                end
                SETUP: begin
                    if (dly_cnt == '0) begin
                        idx           <= '0;
                        spi.spi_tx    <= {6'b100000, led};
                        spi.spi_start <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        dly_cnt <= dly_cnt - 24'd1;
                    end
                end
                LOAD: state <= WAIT_HI;
                WAIT_HI: begin
                    if (spi.spi_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!spi.spi_busy) begin
                        case (idx)
                            3'd0:    x_lo <= spi.spi_rx;
                            3'd1:    x_hi <= spi.spi_rx[1:0];
                            3'd2:    y_lo <= spi.spi_rx;
                            3'd3:    y_hi <= spi.spi_rx[1:0];
                            default: btn  <= spi.spi_rx[2:0];
                        endcase
                        if (idx == 3'd4) begin
                            dly_cnt <= HOLD_LD;
                            state   <= HOLD;
                        end else begin
                            idx     <= idx + 3'd1;
                            dly_cnt <= GAP_LD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (dly_cnt == '0) begin
                        spi.spi_tx    <= 8'h00;  // bytes 1-4 are dummy reads
                        spi.spi_start <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        dly_cnt <= dly_cnt - 24'd1;
                    end
                end
                HOLD: begin
                    if (dly_cnt == '0) begin
                        // Outputs latch on DONE entry so they are stable with the strobe.
                        spi.ss_n     <= 1'b1;
                        sample_valid <= 1'b1;
                        x_pos        <= x_new;
                        y_pos        <= y_new;
                        buttons      <= btn;
`ifdef JSTK_DIR_EN
                        if (mag >= 11'(DIR_DEADBAND)) begin
                            dir_valid <= 1'b1;
                            if (y_win) dir <= dy[10] ? 2'b10 : 2'b00;
                            else       dir <= dx[10] ? 2'b11 : 2'b01;
                        end
`endif
                        state <= DONE;
                    end else begin
                        dly_cnt <= dly_cnt - 24'd1;
                    end
                end
                DONE: begin
                    frame_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
